// File: rtl/adder_accumulator.sv
// Streaming accumulator: sums NUM_OPS signed 4-bit operands through a ripple adder,
// tracking carry-outs and sticky signed overflow, and hands the result out on valid/ready.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; last result still readable
//   ACCUM | accepting operand beats until remaining reaches zero
//   DONE  | result presented on out_valid until out_ready

module adder_4bits #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    always_comb begin
        logic carry;
        logic carry_msb;
        carry     = cin;
        carry_msb = 1'b0;
        sum       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                carry_msb = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout     = carry;
        // Signed overflow: carry into the sign bit differs from carry out of it.
        overflow = carry ^ carry_msb;
    end
endmodule

module adder_accumulator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_sum,
    output logic [CNT_W-1:0] carry_count,
    output logic             ovf_sticky,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic             beat;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

    adder_4bits #(.WIDTH(WIDTH)) u_adder (
        .a        (acc_sum),
        .b        (in_data),
        .cin      (1'b0),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    assign beat = in_valid && (state == ACCUM);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_ops != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && remaining == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc_sum     <= '0;
            carry_count <= '0;
            ovf_sticky  <= 1'b0;
            remaining   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                acc_sum     <= '0;
                carry_count <= '0;
                ovf_sticky  <= 1'b0;
                remaining   <= num_ops;
            end else if (beat) begin
                acc_sum    <= add_sum;
                ovf_sticky <= ovf_sticky | add_ovf;
                // Carry count pins at all-ones rather than wrapping.
                if (add_cout && !(&carry_count)) begin
                    carry_count <= carry_count + CNT_W'(1);
                end
                remaining <= remaining - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench for adder_accumulator: a behavioural arithmetic model pushes expected
// results into a scoreboard queue that is popped when the DUT raises out_valid.
module tb_adder_accumulator;
    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [3:0] sum;
        logic [3:0] carry;
        logic       ovf;
    } res_t;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, in_ready, out_valid, out_ready, ovf_sticky, busy;
    logic [CNT_W-1:0] num_ops, carry_count;
    logic [WIDTH-1:0] in_data, acc_sum;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    adder_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_ops     (num_ops),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .acc_sum     (acc_sum),
        .carry_count (carry_count),
        .ovf_sticky  (ovf_sticky),
        .busy        (busy)
    );

    // Integer-domain reference: signed range test for overflow, unsigned >15 for carry.
    function automatic res_t model(input logic [3:0] ops[$]);
        res_t r;
        int acc, sa, sb_i, carries;
        acc = 0; carries = 0;
        r = '0;
        foreach (ops[i]) begin
            sa   = (acc > 7) ? acc - 16 : acc;
            sb_i = (int'(ops[i]) > 7) ? int'(ops[i]) - 16 : int'(ops[i]);
            if (sa + sb_i > 7 || sa + sb_i < -8) r.ovf = 1'b1;
            if (acc + int'(ops[i]) > 15 && carries < 15) carries++;
            acc = (acc + int'(ops[i])) % 16;
        end
        r.sum   = 4'(acc);
        r.carry = 4'(carries);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        start   = 1'b1;
        num_ops = 4'(n);
        tick();
        start   = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [3:0] ops[$]);
        sb.push_back(model(ops));
        start_job(ops.size());
        foreach (ops[i]) send_beat(ops[i]);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, busy, acc_sum, carry_count, ovf_sticky} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %b want all zero",
                {in_ready, out_valid, busy, acc_sum, carry_count, ovf_sticky}); end
        rst = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000)
            begin errors++; $display("FAIL idle_after_reset: got %b want 000",
                {in_ready, out_valid, busy}); end
    endtask

    task automatic test_arith;
        logic [3:0] ops[$];
        res_t exp;
        int   lat;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: ops = '{4'd1, 4'd2, 4'd4};
                1: ops = '{4'd7, 4'd2};
                2: ops = '{4'hF, 4'h1};
                3: ops = '{4'h8, 4'h8};
                default: begin
                    ops.delete();
                    for (int i = 0; i < 15; i++) ops.push_back(4'hF);
                end
            endcase
            run_job(ops);
            wait_out(lat);
            checks++;
            if (lat != 0 || out_valid !== 1'b1)
                begin errors++; $display("FAIL arith%0d_latency: got %0d extra clks valid=%b want 0 valid=1",
                    k, lat, out_valid); end
            if (sb.size() == 0) begin
                errors++; $display("FAIL arith%0d_scoreboard: got empty queue want one entry", k);
            end else begin
                exp = sb.pop_front();
                checks++;
                if ({acc_sum, carry_count, ovf_sticky} !== {exp.sum, exp.carry, exp.ovf})
                    begin errors++; $display("FAIL arith%0d_result: got sum=%h carry=%0d ovf=%b want sum=%h carry=%0d ovf=%b",
                        k, acc_sum, carry_count, ovf_sticky, exp.sum, exp.carry, exp.ovf); end
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
                checks++;
                if ({out_valid, busy, acc_sum} !== {2'b00, exp.sum})
                    begin errors++; $display("FAIL arith%0d_idle_hold: got valid=%b busy=%b sum=%h want 0 0 %h",
                        k, out_valid, busy, acc_sum, exp.sum); end
            end
        end
    endtask

    task automatic test_zero_ops;
        logic [3:0] none[$];
        res_t exp;
        sb.push_back(model(none));
        start_job(0);
        exp = sb.pop_front();
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b110)
            begin errors++; $display("FAIL zero_done: got valid/busy/ready=%b want 110",
                {out_valid, busy, in_ready}); end
        checks++;
        if ({acc_sum, carry_count, ovf_sticky} !== {exp.sum, exp.carry, exp.ovf})
            begin errors++; $display("FAIL zero_result: got sum=%h carry=%0d ovf=%b want cleared",
                acc_sum, carry_count, ovf_sticky); end
        start    = 1'b1;
        num_ops  = 4'd3;
        in_valid = 1'b1;
        in_data  = 4'h5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid, acc_sum, carry_count, ovf_sticky} !== {1'b1, exp.sum, exp.carry, exp.ovf})
                begin errors++; $display("FAIL zero_hold%0d: got valid=%b sum=%h carry=%0d ovf=%b want held",
                    i, out_valid, acc_sum, carry_count, ovf_sticky); end
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b000)
            begin errors++; $display("FAIL zero_release: got valid/busy/ready=%b want 000",
                {out_valid, busy, in_ready}); end
    endtask

    task automatic test_gaps;
        res_t exp;
        int   lat;
        sb.push_back(model('{4'd3, 4'd5, 4'd1, 4'd2}));
        start_job(4);
        send_beat(4'd3);
        send_beat(4'd5);
        for (int i = 0; i < 2; i++) begin
            in_data = 4'hF;
            tick();
            checks++;
            if ({in_ready, out_valid, acc_sum, ovf_sticky} !== {2'b10, 4'h8, 1'b1})
                begin errors++; $display("FAIL gap_hold%0d: got ready=%b valid=%b sum=%h ovf=%b want 1 0 8 1",
                    i, in_ready, out_valid, acc_sum, ovf_sticky); end
        end
        send_beat(4'd1);
        send_beat(4'd2);
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (lat != 0 || {acc_sum, carry_count, ovf_sticky} !== {exp.sum, exp.carry, exp.ovf})
            begin errors++; $display("FAIL gap_result: got lat=%0d sum=%h carry=%0d ovf=%b want lat=0 sum=%h carry=%0d ovf=%b",
                lat, acc_sum, carry_count, ovf_sticky, exp.sum, exp.carry, exp.ovf); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset;
        start_job(4);
        send_beat(4'd6);
        send_beat(4'd6);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, acc_sum, carry_count, ovf_sticky} !== '0)
            begin errors++; $display("FAIL mid_reset: got %b want all zero",
                {in_ready, out_valid, busy, acc_sum, carry_count, ovf_sticky}); end
        tick();
        checks++;
        if ({in_ready, busy} !== 2'b00)
            begin errors++; $display("FAIL mid_reset_idle: got ready/busy=%b want 00", {in_ready, busy}); end
    endtask

    task automatic test_back_to_back;
        res_t exp;
        int   lat;
        run_job('{4'd2, 4'd3});
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if ({acc_sum, carry_count, ovf_sticky} !== {exp.sum, exp.carry, exp.ovf})
            begin errors++; $display("FAIL b2b_first: got sum=%h carry=%0d ovf=%b want sum=%h carry=%0d ovf=%b",
                acc_sum, carry_count, ovf_sticky, exp.sum, exp.carry, exp.ovf); end
        start     = 1'b1;
        num_ops   = 4'd2;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, acc_sum} !== {3'b000, exp.sum})
            begin errors++; $display("FAIL b2b_start_ignored: got ready/valid/busy=%b sum=%h want 000 %h",
                {in_ready, out_valid, busy}, acc_sum, exp.sum); end
        run_job('{4'd6, 4'd6});
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (lat != 0 || {acc_sum, carry_count, ovf_sticky} !== {exp.sum, exp.carry, exp.ovf})
            begin errors++; $display("FAIL b2b_second: got lat=%0d sum=%h carry=%0d ovf=%b want lat=0 sum=%h carry=%0d ovf=%b",
                lat, acc_sum, carry_count, ovf_sticky, exp.sum, exp.carry, exp.ovf); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_ops   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_arith();
        test_zero_ops();
        test_gaps();
        test_mid_reset();
        test_back_to_back();
        checks++;
        if (sb.size() != 0)
            begin errors++; $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
